// File: rtl/game_ctrl.sv
// Game state controller: sequences MENU -> PLAY -> RESULT -> MENU (with PAUSE) and runs the
// round countdown. State changes are committed only on the frame-start pulse.
module game_ctrl #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 60,
  parameter int unsigned RESULT_FRAMES  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame_in,
  input  logic       btn_start_in,
  input  logic       btn_back_in,
  input  logic       menu_busy_in,
  input  logic       menu_finished_in,
  input  logic       player_dead_in,
  output logic [1:0] state_out,
  output logic       round_start_out,
  output logic [6:0] seconds_left_out,
  output logic       win_out
);

  localparam int unsigned CntMax =
      (FRAMES_PER_SEC > RESULT_FRAMES) ? FRAMES_PER_SEC : RESULT_FRAMES;
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] FpsLast = CntW'(FRAMES_PER_SEC - 1);
  localparam logic [CntW-1:0] ResLast = CntW'(RESULT_FRAMES - 1);
  localparam logic [6:0] RoundSecs = 7'(ROUND_SECONDS);

  typedef enum logic [1:0] {
    StMenu   = 2'b00,
    StPlay   = 2'b01,
    StResult = 2'b10,
    StPause  = 2'b11
  } state_e;

  state_e          state_q, state_d, pend_q, pend_d;
  logic            pend_v_q, pend_v_d;
  logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
  logic [6:0]      seconds_q, seconds_d;
  logic            win_q, win_d;
  logic            round_start_q, round_start_d;

  logic   timeout, res_done, ev_v, ev_win, take_new, commit, eff_win;
  state_e ev_st, eff_st;

  // Within any one state, leaving for RESULT or MENU outranks PAUSE or PLAY.
  function automatic logic rank_hi(input state_e t);
    return (t == StResult) || (t == StMenu);
  endfunction

  assign timeout  = new_frame_in && (state_q == StPlay) && (frame_cnt_q == FpsLast) &&
                    (seconds_q == 7'd1);
  assign res_done = new_frame_in && (state_q == StResult) && (frame_cnt_q == ResLast);

  always_comb begin
    ev_v   = 1'b0;
    ev_st  = state_q;
    ev_win = 1'b0;
    unique case (state_q)
      StMenu: begin
        if (btn_start_in && menu_finished_in && !menu_busy_in) begin
          ev_v  = 1'b1;
          ev_st = StPlay;
        end
      end
      StPlay: begin
        if (player_dead_in) begin
          ev_v  = 1'b1;
          ev_st = StResult;
        end else if (timeout) begin
          ev_v   = 1'b1;
          ev_st  = StResult;
          ev_win = 1'b1;
        end else if (btn_back_in) begin
          ev_v  = 1'b1;
          ev_st = StPause;
        end
      end
      StPause: begin
        if (btn_back_in) begin
          ev_v  = 1'b1;
          ev_st = StMenu;
        end else if (btn_start_in) begin
          ev_v  = 1'b1;
          ev_st = StPlay;
        end
      end
      StResult: begin
        if (btn_start_in || res_done) begin
          ev_v  = 1'b1;
          ev_st = StMenu;
        end
      end
      default: ;
    endcase
  end

  assign take_new = ev_v && (!pend_v_q || (rank_hi(ev_st) && !rank_hi(pend_q)));
  assign commit   = new_frame_in && (pend_v_q || ev_v);
  assign eff_st   = take_new ? ev_st : pend_q;
  // A held RESULT request in PLAY can only come from a death, so it always loses.
  assign eff_win  = take_new ? ev_win : 1'b0;

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    pend_v_d      = pend_v_q;
    frame_cnt_d   = frame_cnt_q;
    seconds_d     = seconds_q;
    win_d         = win_q;
    round_start_d = 1'b0;

    if (new_frame_in) begin
      if (state_q == StPlay) begin
        if (frame_cnt_q == FpsLast) begin
          frame_cnt_d = '0;
          if (seconds_q != 7'd0) seconds_d = seconds_q - 7'd1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else if (state_q == StResult) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    if (commit) begin
      state_d  = eff_st;
      pend_v_d = 1'b0;
      unique case (eff_st)
        StPlay: begin
          if (state_q == StMenu) begin
            seconds_d     = RoundSecs;
            frame_cnt_d   = '0;
            win_d         = 1'b0;
            round_start_d = 1'b1;
          end
        end
        StResult: begin
          frame_cnt_d = '0;
          win_d       = eff_win;
        end
        StMenu: begin
          frame_cnt_d = '0;
          seconds_d   = 7'd0;
        end
        default: ;
      endcase
    end else if (take_new) begin
      pend_d   = ev_st;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StMenu;
      pend_q        <= StMenu;
      pend_v_q      <= 1'b0;
      frame_cnt_q   <= '0;
      seconds_q     <= 7'd0;
      win_q         <= 1'b0;
      round_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_v_q      <= pend_v_d;
      frame_cnt_q   <= frame_cnt_d;
      seconds_q     <= seconds_d;
      win_q         <= win_d;
      round_start_q <= round_start_d;
    end
  end

  assign state_out        = state_q;
  assign round_start_out  = round_start_q;
  assign seconds_left_out = seconds_q;
  assign win_out          = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: frame-count based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized stimulus.
module tb_game_ctrl;

  localparam int unsigned Fps   = 4;
  localparam int unsigned Round = 3;
  localparam int unsigned ResF  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       new_frame_in = 1'b0, btn_start_in = 1'b0, btn_back_in = 1'b0;
  logic       menu_busy_in = 1'b0, menu_finished_in = 1'b0, player_dead_in = 1'b0;
  logic [1:0] state_out;
  logic       round_start_out;
  logic [6:0] seconds_left_out;
  logic       win_out;

  int checks = 0;
  int errors = 0;

  game_ctrl #(
    .FRAMES_PER_SEC(Fps),
    .ROUND_SECONDS (Round),
    .RESULT_FRAMES (ResF)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .new_frame_in    (new_frame_in),
    .btn_start_in    (btn_start_in),
    .btn_back_in     (btn_back_in),
    .menu_busy_in    (menu_busy_in),
    .menu_finished_in(menu_finished_in),
    .player_dead_in  (player_dead_in),
    .state_out       (state_out),
    .round_start_out (round_start_out),
    .seconds_left_out(seconds_left_out),
    .win_out         (win_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: 0 MENU, 1 PLAY, 2 RESULT, 3 PAUSE. Round time is derived from the
  // number of frames spent in PLAY; requests carry a numeric priority.
  int m_st, m_pend_t, m_pend_p, m_play_frames, m_res_frames, m_secs;
  bit m_pend_w, m_win, m_rs;

  always @(posedge clk or negedge rst) begin
    int nt, np;
    bit nw;
    if (!rst) begin
      m_st = 0; m_pend_t = 0; m_pend_p = 0; m_pend_w = 0;
      m_play_frames = 0; m_res_frames = 0; m_secs = 0; m_win = 0; m_rs = 0;
    end else begin
      nt = 0; np = 0; nw = 0;
      m_rs = 0;
      case (m_st)
        0: if (btn_start_in && menu_finished_in && !menu_busy_in) begin nt = 1; np = 1; end
        1: begin
          if (player_dead_in) begin nt = 2; np = 3; nw = 0; end
          else if (new_frame_in && (m_play_frames + 1 == Round * Fps)) begin
            nt = 2; np = 2; nw = 1;
          end
          else if (btn_back_in) begin nt = 3; np = 1; end
        end
        2: if (btn_start_in || (new_frame_in && (m_res_frames + 1 == ResF))) begin
          nt = 0; np = 1;
        end
        default: begin
          if (btn_back_in) begin nt = 0; np = 2; end
          else if (btn_start_in) begin nt = 1; np = 1; end
        end
      endcase
      if (np > m_pend_p) begin m_pend_t = nt; m_pend_p = np; m_pend_w = nw; end
      if (new_frame_in) begin
        if (m_st == 1) begin
          m_play_frames++;
          m_secs = Round - m_play_frames / Fps;
        end
        if (m_st == 2) m_res_frames++;
        if (m_pend_p > 0) begin
          case (m_pend_t)
            0: m_secs = 0;
            1: if (m_st == 0) begin m_play_frames = 0; m_secs = Round; m_win = 0; m_rs = 1; end
            2: begin m_res_frames = 0; m_win = m_pend_w; end
            default: ;
          endcase
          m_st = m_pend_t;
          m_pend_p = 0;
        end
      end
    end
  end

  // Single compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("model_state", int'(state_out), m_st);
      check("model_round_start", int'(round_start_out), int'(m_rs));
      check("model_seconds", int'(seconds_left_out), m_secs);
      check("model_win", int'(win_out), int'(m_win));
    end
  end

  task automatic tick(input logic nf, input logic st, input logic bk);
    @(negedge clk);
    new_frame_in = nf;
    btn_start_in = st;
    btn_back_in  = bk;
  endtask

  task automatic frame();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic enter_play();
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    check("reset_state", int'(state_out), 0);
    check("reset_seconds", int'(seconds_left_out), 0);
    check("reset_win", int'(win_out), 0);
    frames(4);
    check("idle_state", int'(state_out), 0);

    // Start while busy is ignored.
    menu_finished_in = 1'b1;
    menu_busy_in = 1'b1;
    enter_play();
    check("busy_start_ignored", int'(state_out), 0);
    menu_busy_in = 1'b0;

    // New round, then run to timeout.
    enter_play();
    check("start_state", int'(state_out), 1);
    check("start_pulse", int'(round_start_out), 1);
    check("start_seconds", int'(seconds_left_out), 3);
    tick(1'b0, 1'b0, 1'b0);
    check("start_pulse_one_cycle", int'(round_start_out), 0);
    frames(4);
    check("after_4_frames", int'(seconds_left_out), 2);
    frames(7);
    check("after_11_frames_state", int'(state_out), 1);
    check("after_11_frames_secs", int'(seconds_left_out), 1);
    frame();
    check("timeout_state", int'(state_out), 2);
    check("timeout_win", int'(win_out), 1);
    check("timeout_secs", int'(seconds_left_out), 0);
    frames(4);
    check("result_hold", int'(state_out), 2);
    frame();
    check("result_auto_menu", int'(state_out), 0);
    check("menu_keeps_win", int'(win_out), 1);

    // Pause / resume / back to menu.
    enter_play();
    frames(5);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("event_needs_frame", int'(state_out), 1);
    frame();
    check("pause_state", int'(state_out), 3);
    frames(8);
    check("pause_frozen_state", int'(state_out), 3);
    check("pause_frozen_secs", int'(seconds_left_out), 2);
    enter_play();
    check("resume_state", int'(state_out), 1);
    check("resume_no_pulse", int'(round_start_out), 0);
    check("resume_secs", int'(seconds_left_out), 2);
    tick(1'b0, 1'b0, 1'b1);
    frame();
    check("pause_again", int'(state_out), 3);
    tick(1'b0, 1'b1, 1'b1);
    frame();
    check("pause_both_menu", int'(state_out), 0);

    // Death on the frame of the final decrement.
    enter_play();
    frames(11);
    player_dead_in = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    player_dead_in = 1'b0;
    tick(1'b0, 1'b0, 1'b0);
    check("dead_final_state", int'(state_out), 2);
    check("dead_final_win", int'(win_out), 0);
    enter_play();
    check("result_start_menu", int'(state_out), 0);

    // Back then death before the frame: death outranks pause.
    enter_play();
    tick(1'b0, 1'b0, 1'b1);
    player_dead_in = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    player_dead_in = 1'b0;
    frame();
    check("dead_over_pause_state", int'(state_out), 2);
    check("dead_over_pause_win", int'(win_out), 0);
    frames(5);
    check("dead_result_menu", int'(state_out), 0);

    // Asynchronous reset mid-round.
    enter_play();
    frames(4);
    check("pre_reset_secs", int'(seconds_left_out), 2);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", int'(state_out), 0);
    check("async_rst_secs", int'(seconds_left_out), 0);
    check("async_rst_pulse", int'(round_start_out), 0);
    check("async_rst_win", int'(win_out), 0);
    @(negedge clk);
    rst = 1'b1;
    frames(3);
    check("post_reset_menu", int'(state_out), 0);
    check("post_reset_pulse", int'(round_start_out), 0);

    // Randomized phase against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      new_frame_in     = ($urandom_range(0, 4) == 0);
      btn_start_in     = ($urandom_range(0, 11) == 0);
      btn_back_in      = ($urandom_range(0, 29) == 0);
      menu_busy_in     = ($urandom_range(0, 3) == 0);
      menu_finished_in = ($urandom_range(0, 3) != 0);
      if (player_dead_in) player_dead_in = ($urandom_range(0, 3) != 0);
      else player_dead_in = ($urandom_range(0, 79) == 0);
      if (i % 1000 == 500) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    tick(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
